// File: rtl/rec_sram_writer_pkg.sv
// Shared types and constants for the recorder-to-SRAM write path.
package rec_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  // SRAM strobes are active-low; "off" is the idle level.
  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REC,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_FULL
  } rec_state_t;

  function automatic logic in_write(input rec_state_t s);
    return (s == S_SETUP) || (s == S_PULSE) || (s == S_HOLD);
  endfunction

endpackage

// File: rtl/rec_sram_writer_if.sv
// Sample input strobe plus the external SRAM write bus.
interface rec_sram_if
  import rec_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              i_sample_valid;
  logic [DATA_W-1:0] i_sample;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_sram_dq;
  logic              o_sram_dq_oe;
  logic              o_sram_we_n;
  logic              o_sram_ce_n;
  logic              o_sram_oe_n;
  logic              o_sram_lb_n;
  logic              o_sram_ub_n;

  modport master (
    input  i_sample_valid, i_sample,
    output o_sram_addr, o_sram_dq, o_sram_dq_oe,
    output o_sram_we_n, o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n
  );

  modport slave (
    output i_sample_valid, i_sample,
    input  o_sram_addr, o_sram_dq, o_sram_dq_oe,
    input  o_sram_we_n, o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n
  );
endinterface

// File: rtl/rec_sram_writer_fifo.sv
// Two-entry sample FIFO that soaks up a sample burst while an SRAM write is in flight.
module sample_fifo2
  import rec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push  = i_push && (r_count != 2'd2);
  assign w_pop   = i_pop  && (r_count != 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_head  = r_mem[r_rptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/rec_sram_writer.sv
// Writes recorded samples sequentially into the external SRAM and tracks recording length.
module rec_sram_writer
  import rec_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR  = {ADDR_W{1'b1}},
  parameter int                WE_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  rec_sram_if.master        bus,
  output logic              o_busy,
  output logic              o_full,
  output logic              o_overflow,
  output logic [ADDR_W-1:0] o_end_addr
);

  localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WE_CYCLES - 1);

  rec_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq;
  logic              r_dq_oe;
  logic              r_we_n;
  logic              r_ce_n;
  logic              r_lb_n;
  logic              r_ub_n;
  logic              r_busy;
  logic              r_full;
  logic              r_overflow;
  logic [ADDR_W-1:0] r_end_addr;
  logic              r_stop_pend;
  logic [CNT_W-1:0]  r_we_cnt;

  logic              w_accept_state;
  logic              w_smp;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_stop_now;
  logic              w_at_max;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_fifo_head;

  assign w_accept_state = (r_state == S_REC) || in_write(r_state);
  assign w_smp          = bus.i_sample_valid && !i_pause && w_accept_state;
  assign w_push         = w_smp && !w_fifo_full;
  assign w_pop          = (r_state == S_REC) && !i_stop && !i_pause && !w_fifo_empty;
  assign w_stop_now     = r_stop_pend || i_stop;
  assign w_at_max       = (r_addr == MAX_ADDR);
  // Every path back to idle, and every fresh start, discards queued samples.
  assign w_flush = ((r_state == S_REC)  && i_stop)     ||
                   ((r_state == S_HOLD) && w_stop_now) ||
                   ((r_state == S_FULL) && i_stop)     ||
                   ((r_state == S_IDLE) && i_start && !i_stop);

  sample_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (bus.i_sample),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_dq        <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= STROBE_OFF;
      r_ce_n      <= STROBE_OFF;
      r_lb_n      <= STROBE_OFF;
      r_ub_n      <= STROBE_OFF;
      r_busy      <= 1'b0;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_end_addr  <= '0;
      r_stop_pend <= 1'b0;
      r_we_cnt    <= '0;
    end else begin
      if (w_smp && w_fifo_full) r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            r_state     <= S_REC;
            r_addr      <= '0;
            r_end_addr  <= '0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b1;
            r_stop_pend <= 1'b0;
          end
        end
        S_REC: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_pop) begin
            r_state <= S_SETUP;
            r_dq    <= w_fifo_head;
            r_dq_oe <= 1'b1;
            r_ce_n  <= STROBE_ON;
            r_lb_n  <= STROBE_ON;
            r_ub_n  <= STROBE_ON;
            r_we_n  <= STROBE_OFF;
          end
        end
        S_SETUP: begin
          r_stop_pend <= w_stop_now;
          r_we_n      <= STROBE_ON;
          r_we_cnt    <= '0;
          r_state     <= S_PULSE;
        end
        S_PULSE: begin
          r_stop_pend <= w_stop_now;
          if (r_we_cnt == CNT_LAST) begin
            r_we_n  <= STROBE_OFF;
            r_state <= S_HOLD;
          end else begin
            r_we_cnt <= r_we_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          // A stop seen anywhere in the write takes effect once the word is committed.
          r_end_addr  <= r_addr + ADDR_W'(1);
          r_dq_oe     <= 1'b0;
          r_ce_n      <= STROBE_OFF;
          r_lb_n      <= STROBE_OFF;
          r_ub_n      <= STROBE_OFF;
          r_stop_pend <= 1'b0;
          if (w_at_max) r_full <= 1'b1;
          else          r_addr <= r_addr + ADDR_W'(1);
          if (w_stop_now) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_at_max) begin
            r_state <= S_FULL;
          end else begin
            r_state <= S_REC;
          end
        end
        S_FULL: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_sram_addr  = r_addr;
  assign bus.o_sram_dq    = r_dq;
  assign bus.o_sram_dq_oe = r_dq_oe;
  assign bus.o_sram_we_n  = r_we_n;
  assign bus.o_sram_ce_n  = r_ce_n;
  assign bus.o_sram_oe_n  = STROBE_OFF;
  assign bus.o_sram_lb_n  = r_lb_n;
  assign bus.o_sram_ub_n  = r_ub_n;
  assign o_busy           = r_busy;
  assign o_full           = r_full;
  assign o_overflow       = r_overflow;
  assign o_end_addr       = r_end_addr;

endmodule
